// File: rtl/mp64_extmem.sv
// Arbiter and width adapter: a CPU port (single 64-bit beats) and a tile port (512-bit lines
// moved as 8-beat bursts) share one 64-bit memory PHY. The tile port has fixed priority.
module mp64_extmem (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic [31:0]  cpu_addr,
    input  logic [63:0]  cpu_wdata,
    input  logic         cpu_wen,
    output logic [63:0]  cpu_rdata,
    output logic         cpu_ack,
    input  logic         tile_req,
    input  logic [31:0]  tile_addr,
    input  logic [511:0] tile_wdata,
    input  logic         tile_wen,
    output logic [511:0] tile_rdata,
    output logic         tile_ack,
    output logic         phy_req,
    output logic [31:0]  phy_addr,
    output logic [63:0]  phy_wdata,
    output logic         phy_wen,
    input  logic [63:0]  phy_rdata,
    input  logic         phy_ack,
    output logic [3:0]   phy_burst_len
);

    // PHY handshake: phy_req is held high for the whole transaction; each posedge with
    // phy_ack=1 completes one beat. A transaction is 1 beat (CPU) or 8 beats (tile).
    typedef enum logic [1:0] {IDLE, CPU_XFER, TILE_XFER} state_t;

    state_t       state;
    logic [2:0]   beat;
    logic [447:0] wline;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= 3'd0;
            wline         <= '0;
            cpu_rdata     <= '0;
            cpu_ack       <= 1'b0;
            tile_rdata    <= '0;
            tile_ack      <= 1'b0;
            phy_req       <= 1'b0;
            phy_addr      <= '0;
            phy_wdata     <= '0;
            phy_wen       <= 1'b0;
            phy_burst_len <= 4'd0;
        end else begin
            cpu_ack  <= 1'b0;
            tile_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (tile_req) begin
                        state         <= TILE_XFER;
                        beat          <= 3'd0;
                        wline         <= tile_wdata[511:64];
                        phy_req       <= 1'b1;
                        phy_addr      <= tile_addr;
                        phy_wen       <= tile_wen;
                        phy_wdata     <= tile_wdata[63:0];
                        phy_burst_len <= 4'd8;
                    end else if (cpu_req) begin
                        state         <= CPU_XFER;
                        phy_req       <= 1'b1;
                        phy_addr      <= cpu_addr;
                        phy_wen       <= cpu_wen;
                        phy_wdata     <= cpu_wdata;
                        phy_burst_len <= 4'd1;
                    end
                end
                CPU_XFER: begin
                    if (phy_ack) begin
                        cpu_rdata     <= phy_rdata;
                        cpu_ack       <= 1'b1;
                        phy_req       <= 1'b0;
                        phy_burst_len <= 4'd0;
                        state         <= IDLE;
                    end
                end
                TILE_XFER: begin
                    if (phy_ack) begin
                        if (!phy_wen) begin
                            tile_rdata[{beat, 6'd0} +: 64] <= phy_rdata;
                        end else begin
                            // Remaining write beats shift down so the next one is always at the bottom.
                            phy_wdata <= wline[63:0];
                            wline     <= {64'd0, wline[447:64]};
                        end
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) begin
                            tile_ack      <= 1'b1;
                            phy_req       <= 1'b0;
                            phy_burst_len <= 4'd0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_extmem.sv
// Directed bench for mp64_extmem: a CPU vector table plus hand-written tile bursts,
// arbitration and mid-transaction reset sequences.
module tb_mp64_extmem;

    logic         clk;
    logic         rst_n;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic [63:0]  cpu_wdata;
    logic         cpu_wen;
    logic [63:0]  cpu_rdata;
    logic         cpu_ack;
    logic         tile_req;
    logic [31:0]  tile_addr;
    logic [511:0] tile_wdata;
    logic         tile_wen;
    logic [511:0] tile_rdata;
    logic         tile_ack;
    logic         phy_req;
    logic [31:0]  phy_addr;
    logic [63:0]  phy_wdata;
    logic         phy_wen;
    logic [63:0]  phy_rdata;
    logic         phy_ack;
    logic [3:0]   phy_burst_len;

    int n_checks = 0;
    int n_pass   = 0;

    mp64_extmem dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .tile_req(tile_req), .tile_addr(tile_addr), .tile_wdata(tile_wdata), .tile_wen(tile_wen),
        .tile_rdata(tile_rdata), .tile_ack(tile_ack),
        .phy_req(phy_req), .phy_addr(phy_addr), .phy_wdata(phy_wdata), .phy_wen(phy_wen),
        .phy_rdata(phy_rdata), .phy_ack(phy_ack), .phy_burst_len(phy_burst_len)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        string       name;
        logic        creq;
        logic [31:0] caddr;
        logic [63:0] cwdata;
        logic        cwen;
        logic        pack;
        logic [63:0] prdata;
        logic        e_req;
        logic [3:0]  e_len;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [63:0] e_wdata;
        logic        e_cack;
        logic [63:0] e_crdata;
    } vec_t;

    vec_t vecs[8];
    logic [511:0] exp_line;
    logic [63:0]  beat_val;

    initial begin
        vecs[0] = '{"idle",            0, 32'h0,         64'h0,                 0, 0, 64'h0,
                    0, 4'd0, 32'h0,         0, 64'h0,                 0, 64'h0};
        vecs[1] = '{"cpu_rd_issue",    1, 32'h80000100, 64'h0,                 0, 0, 64'h0,
                    1, 4'd1, 32'h80000100, 0, 64'h0,                 0, 64'h0};
        vecs[2] = '{"cpu_rd_wait",     1, 32'h80000100, 64'h0,                 0, 0, 64'h0,
                    1, 4'd1, 32'h80000100, 0, 64'h0,                 0, 64'h0};
        vecs[3] = '{"cpu_rd_ack",      1, 32'h80000100, 64'h0,                 0, 1, 64'hDEADBEEF12345678,
                    0, 4'd0, 32'h80000100, 0, 64'h0,                 1, 64'hDEADBEEF12345678};
        vecs[4] = '{"cpu_rd_done",     0, 32'h0,         64'h0,                 0, 0, 64'h0,
                    0, 4'd0, 32'h80000100, 0, 64'h0,                 0, 64'hDEADBEEF12345678};
        vecs[5] = '{"cpu_wr_issue",    1, 32'h80000200, 64'hCAFEBABE00000001, 1, 0, 64'h0,
                    1, 4'd1, 32'h80000200, 1, 64'hCAFEBABE00000001, 0, 64'hDEADBEEF12345678};
        vecs[6] = '{"cpu_wr_ack",      1, 32'h80000200, 64'hCAFEBABE00000001, 1, 1, 64'hDEADBEEF12345678,
                    0, 4'd0, 32'h80000200, 1, 64'hCAFEBABE00000001, 1, 64'hDEADBEEF12345678};
        vecs[7] = '{"idle_ack_ignored", 0, 32'h0,        64'h0,                 0, 1, 64'h0123456789ABCDEF,
                    0, 4'd0, 32'h80000200, 1, 64'hCAFEBABE00000001, 0, 64'hDEADBEEF12345678};

        rst_n = 1'b0;
        cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wen = 0;
        tile_req = 0; tile_addr = 0; tile_wdata = 0; tile_wen = 0;
        phy_rdata = 0; phy_ack = 0;
        tick();
        tick();
        rst_n = 1'b1;

        // CPU table: drive, clock once, compare
        for (int i = 0; i < 8; i++) begin
            cpu_req = vecs[i].creq; cpu_addr = vecs[i].caddr;
            cpu_wdata = vecs[i].cwdata; cpu_wen = vecs[i].cwen;
            phy_ack = vecs[i].pack; phy_rdata = vecs[i].prdata;
            tick();
            chk({vecs[i].name, ".phy_req"},   64'(phy_req),       64'(vecs[i].e_req));
            chk({vecs[i].name, ".burst_len"}, 64'(phy_burst_len), 64'(vecs[i].e_len));
            chk({vecs[i].name, ".phy_addr"},  64'(phy_addr),      64'(vecs[i].e_addr));
            chk({vecs[i].name, ".phy_wen"},   64'(phy_wen),       64'(vecs[i].e_wen));
            chk({vecs[i].name, ".phy_wdata"}, phy_wdata,          vecs[i].e_wdata);
            chk({vecs[i].name, ".cpu_ack"},   64'(cpu_ack),       64'(vecs[i].e_cack));
            chk({vecs[i].name, ".cpu_rdata"}, cpu_rdata,          vecs[i].e_crdata);
            chk({vecs[i].name, ".tile_ack"},  64'(tile_ack),      64'h0);
        end
        phy_ack = 0;

        // Tile read with an idle cycle before every beat
        tile_req = 1; tile_addr = 32'hA0000000; tile_wen = 0;
        tick();
        chk("trd.phy_req",   64'(phy_req),       64'h1);
        chk("trd.burst_len", 64'(phy_burst_len), 64'h8);
        chk("trd.phy_addr",  64'(phy_addr),      64'hA0000000);
        chk("trd.phy_wen",   64'(phy_wen),       64'h0);
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            phy_ack = 0;
            tick();
            chk("trd.wait_req", 64'(phy_req),  64'h1);
            chk("trd.wait_ack", 64'(tile_ack), 64'h0);
            beat_val = {32'hBEAD0000, 16'(k), 16'h0};
            exp_line[k*64 +: 64] = beat_val;
            phy_ack = 1; phy_rdata = beat_val;
            tick();
            chk("trd.tile_ack", 64'(tile_ack), (k == 7) ? 64'h1 : 64'h0);
            chk("trd.phy_req",  64'(phy_req),  (k == 7) ? 64'h0 : 64'h1);
        end
        chk("trd.end_len", 64'(phy_burst_len), 64'h0);
        tile_req = 0; phy_ack = 0;
        tick();
        chk("trd.ack_pulse", 64'(tile_ack), 64'h0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("trd.slice%0d", k), tile_rdata[k*64 +: 64], exp_line[k*64 +: 64]);
        chk("trd.slice0_const", tile_rdata[63:0],    64'hBEAD000000000000);
        chk("trd.slice7_const", tile_rdata[511:448], 64'hBEAD000000070000);

        // Tile write: back-to-back acks advance the write beat
        for (int k = 0; k < 8; k++) tile_wdata[k*64 +: 64] = 64'hAA000000 + 64'(k);
        tile_req = 1; tile_addr = 32'hB0000000; tile_wen = 1;
        tick();
        chk("twr.phy_wen",   64'(phy_wen),       64'h1);
        chk("twr.burst_len", 64'(phy_burst_len), 64'h8);
        chk("twr.phy_addr",  64'(phy_addr),      64'hB0000000);
        chk("twr.wdata0",    phy_wdata,          64'hAA000000);
        phy_ack = 1; phy_rdata = 64'hFFFFFFFFFFFFFFFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 7) chk($sformatf("twr.wdata%0d", k + 1), phy_wdata, 64'hAA000000 + 64'(k + 1));
            chk("twr.tile_ack", 64'(tile_ack), (k == 7) ? 64'h1 : 64'h0);
        end
        chk("twr.phy_req_off", 64'(phy_req), 64'h0);
        chk("twr.rdata_held",  tile_rdata[511:448], 64'hBEAD000000070000);
        tile_req = 0; tile_wen = 0; phy_ack = 0;
        tick();

        // Simultaneous requests: tile first, then pending CPU
        cpu_req = 1; cpu_addr = 32'h90000000; cpu_wen = 0;
        tile_req = 1; tile_addr = 32'hC0000000; tile_wen = 0;
        tick();
        chk("arb.tile_len",  64'(phy_burst_len), 64'h8);
        chk("arb.tile_addr", 64'(phy_addr),      64'hC0000000);
        phy_ack = 1;
        for (int k = 0; k < 8; k++) begin
            phy_rdata = 64'h1111 * 64'(k + 1);
            tick();
            chk("arb.cpu_ack_low", 64'(cpu_ack), 64'h0);
        end
        chk("arb.tile_ack", 64'(tile_ack), 64'h1);
        chk("arb.slice3",   tile_rdata[255:192], 64'h4444);
        tile_req = 0; phy_ack = 0;
        tick();
        chk("arb.cpu_req",  64'(phy_req),       64'h1);
        chk("arb.cpu_len",  64'(phy_burst_len), 64'h1);
        chk("arb.cpu_addr", 64'(phy_addr),      64'h90000000);
        phy_ack = 1; phy_rdata = 64'h0BADF00D0BADF00D;
        tick();
        chk("arb.cpu_ack",   64'(cpu_ack), 64'h1);
        chk("arb.cpu_rdata", cpu_rdata,    64'h0BADF00D0BADF00D);
        cpu_req = 0; phy_ack = 0;
        tick();
        chk("arb.cpu_ack_pulse", 64'(cpu_ack), 64'h0);

        // Reset in the middle of a CPU transfer aborts it without an ack
        cpu_req = 1; cpu_addr = 32'h80000300;
        tick();
        chk("rst.started", 64'(phy_req), 64'h1);
        rst_n = 0;
        #1;
        chk("rst.phy_req",   64'(phy_req),       64'h0);
        chk("rst.burst_len", 64'(phy_burst_len), 64'h0);
        chk("rst.cpu_rdata", cpu_rdata,          64'h0);
        chk("rst.tile_rd0",  tile_rdata[63:0],   64'h0);
        cpu_req = 0; phy_ack = 1;
        tick();
        rst_n = 1;
        tick();
        chk("rst.no_cpu_ack", 64'(cpu_ack), 64'h0);
        chk("rst.idle",       64'(phy_req), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
